lfsr_noise_gen: RTL and testbench
=================================

Name: lfsr_noise_gen

Overview:
Parametrised pseudo-random noise source for the signal-generator noise channel. It has a WIDTH-bit LFSR with runtime-programmable taps and a runtime-loadable seed. A programmable rate divider sets the step rate. Outputs are a serial noise bit and an OUT_WIDTH-bit assembled noise word with a valid strobe. All-zero lockup is detected and recovered automatically.

Parameters:
WIDTH, 16, LFSR register width (>=4)
OUT_WIDTH, 8, bits per assembled noise word (2..WIDTH)
DIV_WIDTH, 16, width of rate divider reload value

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  run gate; low freezes all state
seed_load  input  1  one-cycle request to load seed into LFSR
seed  input  WIDTH  seed value for seed_load
taps  input  WIDTH  feedback tap mask, bit i = LFSR bit i participates
rate_div  input  DIV_WIDTH  step period minus one, in enabled cycles
noise  output  1  serial noise bit, registered
noise_word  output  OUT_WIDTH  last completed noise word, registered
word_valid  output  1  one-cycle pulse when noise_word updates
lockup  output  1  one-cycle pulse on zero-state recovery or zero seed

Behaviour:
- The design uses one clock domain. Reset is synchronous and active-low on rst_n. Every register is initialised on the rising clk edge where rst_n=0.
- Reset values: lfsr=all-ones, div_cnt=0, bit_cnt=0, shift buffer=0, noise=0, noise_word=0, word_valid=0, lockup=0.
- Divider: while enable=1 and no seed_load, div_cnt increments each cycle. When div_cnt==rate_div, a step fires and div_cnt returns to 0. rate_div=0 gives one step per cycle. If rate_div changes mid-count to a value below div_cnt, the counter wraps at 2^DIV_WIDTH-1 and then matches. Bench must not rely on other behaviour.
- Step (Fibonacci, default): fb = XOR-reduce(lfsr & taps); lfsr <= {lfsr[WIDTH-2:0], fb}; noise <= lfsr[WIDTH-1] (pre-step MSB). noise is visible the cycle after the step edge.
- Lockup: if lfsr==0 when a step fires, lfsr <= all-ones, noise <= 0, and lockup pulses for one cycle. The word assembler still takes that 0 bit.
- Word assembler: on each step, shift buffer <= {buf[OUT_WIDTH-2:0], new noise bit}, so the first bit ends in the MSB, and bit_cnt increments. When bit_cnt reaches OUT_WIDTH-1 on a step, noise_word <= completed buffer, word_valid=1 for exactly that cycle, and bit_cnt <= 0.
- seed_load (sampled only when rst_n=1; takes effect even if enable=0) has priority over a step in the same cycle. Effects: lfsr <= seed, div_cnt <= 0, bit_cnt <= 0, buffer cleared; noise and noise_word hold their values.
- If seed==0 on load, lfsr <= all-ones instead and lockup pulses.
- enable=0: div_cnt, lfsr, bit_cnt, noise and noise_word hold; word_valid=0. Any lockup pulse already in progress still completes its single cycle.
- taps changes take effect on the next step; there is no internal taps register.
- Reset asserted mid-word discards the partial word; word_valid never fires from reset.

Optional Feature:
LFSR_GALOIS_EN. When defined, the step uses Galois form: msb = lfsr[WIDTH-1]; lfsr <= {lfsr[WIDTH-2:0],1'b0} ^ (msb ? taps : 0); noise <= msb. Lockup, divider, word assembler and seed rules are unchanged. When not defined, only Fibonacci logic is built, with no Galois gates.

Test Plan:
- Reset, enable=1, rate_div=0, taps=16'hD008 -> first 16 steps give noise=1 and first two word_valid pulses give noise_word=8'hFF. Period of lfsr back to 16'hFFFF = 65535 steps.
- rate_div=3, enable=1 for 40 cycles -> exactly 10 steps; word_valid once at step 8. Drop enable for 5 cycles -> lfsr and div_cnt unchanged.
- seed_load with seed=0 -> lfsr=16'hFFFF and lockup=1 for one cycle. seed_load with seed=16'h0001 in the same cycle as a due step -> lfsr=16'h0001, no step, bit_cnt=0.
- taps=0 from reset, rate_div=0 -> lfsr=0 after 16 steps; on step 17 lockup pulses, noise=0, lfsr=16'hFFFF.
- Assert rst_n=0 for one cycle after 5 steps -> all outputs 0 and lfsr=16'hFFFF next cycle; next word_valid after a further 8 steps.
- With LFSR_GALOIS_EN, taps=16'h002D (x^16+x^5+x^3+x^2+1), reset -> period 65535; first step from 16'hFFFF gives lfsr=16'hFFD3, noise=1.

Source files
------------

// File: rtl/lfsr_noise_gen.sv
// Pseudo-random noise source: programmable-tap LFSR, rate divider, serial bit and word output.
// Define LFSR_GALOIS_EN to build the Galois step instead of the default Fibonacci step.
module lfsr_noise_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    input  logic [WIDTH-1:0]     taps,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic                 noise,
    output logic [OUT_WIDTH-1:0] noise_word,
    output logic                 word_valid,
    output logic                 lockup
);

    localparam int unsigned CNT_W = $clog2(OUT_WIDTH);

    logic [WIDTH-1:0]     lfsr_q,    lfsr_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [OUT_WIDTH-1:0] shift_q,   shift_d;
    logic [OUT_WIDTH-1:0] word_q,    word_d;
    logic                 noise_q,   noise_d;
    logic                 valid_q,   valid_d;
    logic                 lockup_q,  lockup_d;

    logic                 step_c;
    logic [WIDTH-1:0]     lfsr_step_c;
    logic                 new_bit_c;

    assign step_c = enable && !seed_load && (div_cnt_q == rate_div);

    // One LFSR advance, ignoring the all-zero case handled below
    always_comb begin
`ifdef LFSR_GALOIS_EN
        lfsr_step_c = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? taps : '0);
`else
        lfsr_step_c = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps)};
`endif
    end

    always_comb begin
        lfsr_d    = lfsr_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        noise_d   = noise_q;
        valid_d   = 1'b0;
        lockup_d  = 1'b0;
        new_bit_c = 1'b0;

        if (seed_load) begin
            // A zero seed would lock the register, so substitute all-ones and flag it
            lfsr_d    = (seed == '0) ? '1 : seed;
            lockup_d  = (seed == '0);
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (enable) begin
            if (step_c) begin
                div_cnt_d = '0;
                if (lfsr_q == '0) begin
                    lfsr_d    = '1;
                    new_bit_c = 1'b0;
                    lockup_d  = 1'b1;
                end else begin
                    lfsr_d    = lfsr_step_c;
                    new_bit_c = lfsr_q[WIDTH-1];
                end
                noise_d = new_bit_c;
                shift_d = {shift_q[OUT_WIDTH-2:0], new_bit_c};
                if (bit_cnt_q == CNT_W'(OUT_WIDTH - 1)) begin
                    word_d    = shift_d;
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q    <= '1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            noise_q   <= 1'b0;
            valid_q   <= 1'b0;
            lockup_q  <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            noise_q   <= noise_d;
            valid_q   <= valid_d;
            lockup_q  <= lockup_d;
        end
    end

    assign noise      = noise_q;
    assign noise_word = word_q;
    assign word_valid = valid_q;
    assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Directed bench for lfsr_noise_gen; expected values are hand-derived from the step rules.
module tb_lfsr_noise_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed;
    logic [15:0] taps;
    logic [15:0] rate_div;
    logic        noise;
    logic [7:0]  noise_word;
    logic        word_valid;
    logic        lockup;

    int n_cmp = 0;
    int n_bad = 0;
    int wv_cnt;

    lfsr_noise_gen #(.WIDTH(16), .OUT_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed       (seed),
        .taps       (taps),
        .rate_div   (rate_div),
        .noise      (noise),
        .noise_word (noise_word),
        .word_valid (word_valid),
        .lockup     (lockup)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = '0;
        taps = 16'hD008; rate_div = '0;
        tick(); tick();
        chk("rst_noise", 32'(noise), 32'h0);
        chk("rst_word", 32'(noise_word), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_lockup", 32'(lockup), 32'h0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hFFFF);

`ifdef LFSR_GALOIS_EN
        // Galois form: FFFF -> FFD3 -> FF8B with taps 002D
        taps = 16'h002D;
        rst_n = 1'b1; enable = 1'b1;
        tick();
        chk("gal_s1_lfsr", 32'(dut.lfsr_q), 32'hFFD3);
        chk("gal_s1_noise", 32'(noise), 32'h1);
        tick();
        chk("gal_s2_lfsr", 32'(dut.lfsr_q), 32'hFF8B);
        enable = 1'b0;
`else
        // Fibonacci, taps D008, one step per cycle from all-ones
        rst_n = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("fib_noise_%0d", k), 32'(noise), 32'h1);
            chk($sformatf("fib_valid_%0d", k), 32'(word_valid), 32'((k == 8) || (k == 16)));
            if (k == 8 || k == 16)
                chk($sformatf("fib_word_%0d", k), 32'(noise_word), 32'hFF);
            if (k == 8)
                chk("fib_lfsr_8", 32'(dut.lfsr_q), 32'hFF0F);
        end

        // rate_div=3: 40 enabled cycles -> 10 steps, one word
        rst_n = 1'b0; tick();
        rst_n = 1'b1; enable = 1'b1; rate_div = 16'd3;
        wv_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (word_valid) wv_cnt++;
        end
        chk("div_wv_count", 32'(wv_cnt), 32'd1);
        chk("div_lfsr_10", 32'(dut.lfsr_q), 32'hFC3C);
        chk("div_cnt_wrap", 32'(dut.div_cnt_q), 32'h0);
        chk("div_noise", 32'(noise), 32'h1);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("hold_lfsr", 32'(dut.lfsr_q), 32'hFC3C);
        chk("hold_div", 32'(dut.div_cnt_q), 32'h0);
        chk("hold_noise", 32'(noise), 32'h1);
        chk("hold_valid", 32'(word_valid), 32'h0);
`endif

        // Zero seed substitutes all-ones and pulses lockup, even with enable low
        rate_div = '0;
        seed_load = 1'b1; seed = 16'h0000;
        tick();
        seed_load = 1'b0;
        chk("seed0_lfsr", 32'(dut.lfsr_q), 32'hFFFF);
        chk("seed0_lockup", 32'(lockup), 32'h1);
        tick();
        chk("seed0_lockup_end", 32'(lockup), 32'h0);

        // Seed load beats a due step and clears bit count
        taps = 16'hD008; enable = 1'b1;
        tick(); tick(); tick();
        chk("pre_seed_bitcnt", 32'(dut.bit_cnt_q), 32'd3);
        seed_load = 1'b1; seed = 16'h0001;
        tick();
        seed_load = 1'b0;
        chk("seed1_lfsr", 32'(dut.lfsr_q), 32'h0001);
        chk("seed1_bitcnt", 32'(dut.bit_cnt_q), 32'h0);
        chk("seed1_lockup", 32'(lockup), 32'h0);
        tick();
        chk("seed1_step_lfsr", 32'(dut.lfsr_q), 32'h0002);
        chk("seed1_step_noise", 32'(noise), 32'h0);

        // taps=0 drains to zero; step 17 recovers and feeds a 0 into the word
        rst_n = 1'b0; tick();
        rst_n = 1'b1; taps = 16'h0000; enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 16) begin
                chk("lk_lfsr_16", 32'(dut.lfsr_q), 32'h0);
                chk("lk_noise_16", 32'(noise), 32'h1);
                chk("lk_lockup_16", 32'(lockup), 32'h0);
            end
            if (k == 17) begin
                chk("lk_lockup_17", 32'(lockup), 32'h1);
                chk("lk_noise_17", 32'(noise), 32'h0);
                chk("lk_lfsr_17", 32'(dut.lfsr_q), 32'hFFFF);
            end
            if (k == 18) begin
                chk("lk_lockup_18", 32'(lockup), 32'h0);
                chk("lk_noise_18", 32'(noise), 32'h1);
            end
            if (k == 24) begin
                chk("lk_valid_24", 32'(word_valid), 32'h1);
                chk("lk_word_24", 32'(noise_word), 32'h7F);
            end
        end

        // Reset mid-word discards the partial word
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0; tick();
        chk("mid_rst_noise", 32'(noise), 32'h0);
        chk("mid_rst_word", 32'(noise_word), 32'h0);
        chk("mid_rst_valid", 32'(word_valid), 32'h0);
        chk("mid_rst_lfsr", 32'(dut.lfsr_q), 32'hFFFF);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("mid_valid_%0d", k), 32'(word_valid), 32'(k == 8));
        end
        chk("mid_word_8", 32'(noise_word), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
